// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight,
// and presents fetched words to the decoder through the IF/ID register.
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [5:0]      if_op,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pcplus4
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_DISCARD} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_if_valid;
  logic [XLEN-1:0] r_if_instr;
  logic [XLEN-1:0] r_if_pc;
  logic [XLEN-1:0] r_if_pcplus4;
  logic [XLEN-1:0] r_skid_instr;
  logic [XLEN-1:0] r_skid_pc;

  logic            w_consume;
  logic            w_out_free;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_redirect_pc;

  assign w_consume     = r_if_valid & ~stall;
  assign w_out_free    = ~r_if_valid | ~stall;
  assign w_pc_plus4    = r_pc + XLEN'(4);
  assign w_redirect_pc = redirect_pc & ~(XLEN'(3));

  // Request is held low while reset is asserted and during a redirect cycle.
  assign imem_req   = reset & (r_state == S_FETCH) & w_out_free & ~redirect;
  assign imem_addr  = r_pc;

  assign if_valid   = r_if_valid;
  assign if_instr   = r_if_instr;
  assign if_op      = r_if_instr[XLEN-1 -: 6];
  assign if_pc      = r_if_pc;
  assign if_pcplus4 = r_if_pcplus4;

  // The skid buffer is occupied exactly while the FSM sits in S_HOLD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_if_valid   <= 1'b0;
      r_if_instr   <= '0;
      r_if_pc      <= '0;
      r_if_pcplus4 <= '0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
    end else begin
      if (w_consume) begin
        r_if_valid <= 1'b0;
      end
      if (redirect) begin
        r_pc       <= w_redirect_pc;
        r_if_valid <= 1'b0;
        case (r_state)
          S_WAIT, S_DISCARD: r_state <= imem_rvalid ? S_FETCH : S_DISCARD;
          default:           r_state <= S_FETCH;
        endcase
      end else begin
        case (r_state)
          S_FETCH: begin
            if (w_out_free) begin
              r_state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              r_pc <= w_pc_plus4;
              if (w_out_free) begin
                r_if_valid   <= 1'b1;
                r_if_instr   <= imem_rdata;
                r_if_pc      <= r_pc;
                r_if_pcplus4 <= w_pc_plus4;
                r_state      <= S_FETCH;
              end else begin
                r_skid_instr <= imem_rdata;
                r_skid_pc    <= r_pc;
                r_state      <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (w_consume) begin
              r_if_valid   <= 1'b1;
              r_if_instr   <= r_skid_instr;
              r_if_pc      <= r_skid_pc;
              r_if_pcplus4 <= r_skid_pc + XLEN'(4);
              r_state      <= S_FETCH;
            end
          end
          S_DISCARD: begin
            if (imem_rvalid) begin
              r_state <= S_FETCH;
            end
          end
          default: r_state <= S_FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected requests and IF/ID consumptions
// are queued with their cycle numbers; a monitor pops and compares them.
module tb_fetch_stage;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
  } req_t;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [31:0] pcp4;
  } ifid_t;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [5:0]  if_op;
  logic [31:0] if_pc;
  logic [31:0] if_pcplus4;

  logic        req2;
  logic [31:0] addr2;
  logic        rvalid2;
  logic [31:0] rdata2;
  logic        stall2;
  logic        redirect2;
  logic [31:0] redirect_pc2;
  logic        if_valid2;
  logic [31:0] if_instr2;
  logic [5:0]  if_op2;
  logic [31:0] if_pc2;
  logic [31:0] if_pcplus4_2;

  int total;
  int bad;
  int cyc;

  int          mem_lat;
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  logic        inj;
  logic [31:0] inj_data;
  logic        pend2;

  req_t  exp_req[$];
  ifid_t exp_ifid[$];

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_op(if_op),
    .if_pc(if_pc), .if_pcplus4(if_pcplus4)
  );

  fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(req2), .imem_addr(addr2),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .stall(stall2), .redirect(redirect2), .redirect_pc(redirect_pc2),
    .if_valid(if_valid2), .if_instr(if_instr2), .if_op(if_op2),
    .if_pc(if_pc2), .if_pcplus4(if_pcplus4_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'h0000_0000: word = 32'h8C01_0004;
      32'h0000_0004: word = 32'h0000_0820;
      default:       word = 32'hC000_0000 | a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_req(input int c, input logic [31:0] a);
    req_t r;
    r.cyc = c; r.addr = a;
    exp_req.push_back(r);
  endtask

  task automatic push_ifid(input int c, input logic [31:0] pc, input logic [31:0] instr,
                           input logic [5:0] op, input logic [31:0] pcp4);
    ifid_t e;
    e.cyc = c; e.pc = pc; e.instr = instr; e.op = op; e.pcp4 = pcp4;
    exp_ifid.push_back(e);
  endtask

  // Memory model: drives the response at +1, captures new requests at +2.
  always @(negedge clk) begin
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (!reset) begin
      pend = 1'b0;
    end else if (pend) begin
      if (pend_cnt == 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word(pend_addr);
        pend        = 1'b0;
      end else begin
        pend_cnt = pend_cnt - 1;
      end
    end
    if (inj) begin
      imem_rvalid = 1'b1;
      imem_rdata  = inj_data;
    end
    rvalid2 = pend2;
    rdata2  = pend2 ? 32'h0400_0000 : 32'h0;
    #1;
    if (imem_req) begin
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_cnt  = mem_lat;
    end
    pend2 = req2;
  end

  // Monitor: compares every request and every consumed IF/ID word.
  always @(negedge clk) begin
    req_t  r;
    ifid_t e;
    #3;
    if (reset) begin
      if (imem_req) begin
        if (exp_req.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_req: got addr %h expected none (cycle %0d)", imem_addr, cyc);
        end else begin
          r = exp_req.pop_front();
          $display("req  cycle=%0d addr=%h", cyc, imem_addr);
          chk("req_cycle", cyc, r.cyc);
          chk("req_addr", imem_addr, r.addr);
        end
      end
      if (if_valid && !stall) begin
        if (exp_ifid.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ifid: got pc %h expected none (cycle %0d)", if_pc, cyc);
        end else begin
          e = exp_ifid.pop_front();
          $display("ifid cycle=%0d pc=%h instr=%h op=%b", cyc, if_pc, if_instr, if_op);
          chk("ifid_cycle", cyc, e.cyc);
          chk("ifid_pc", if_pc, e.pc);
          chk("ifid_instr", if_instr, e.instr);
          chk("ifid_op", {26'd0, if_op}, {26'd0, e.op});
          chk("ifid_pcplus4", if_pcplus4, e.pcp4);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_if_valid"}, {31'd0, if_valid}, 32'd0);
    chk({tag, "_if_instr"}, if_instr, 32'd0);
    chk({tag, "_if_pc"}, if_pc, 32'd0);
    chk({tag, "_if_pcplus4"}, if_pcplus4, 32'd0);
    chk({tag, "_imem_req"}, {31'd0, imem_req}, 32'd0);
  endtask

  initial begin
    int b;
    total = 0; bad = 0; cyc = 0;
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    inj = 1'b0; inj_data = 32'hDEAD_BEEF; mem_lat = 1;
    pend = 1'b0; pend_addr = '0; pend_cnt = 0; pend2 = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    rvalid2 = 1'b0; rdata2 = '0; stall2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = '0;

    tick();
    tick();
    #3;
    check_reset_outputs("por");

    tick();
    reset = 1'b1;
    b = cyc;
    // Run from reset through stall, redirect-while-waiting and redirect-with-rvalid.
    push_req(b + 0, 32'h0);  push_req(b + 2, 32'h4);  push_req(b + 7, 32'h8);
    push_req(b + 9, 32'hC);  push_req(b + 11, 32'h10); push_req(b + 15, 32'h40);
    push_req(b + 19, 32'h44); push_req(b + 21, 32'h20); push_req(b + 23, 32'h24);
    push_req(b + 25, 32'h28);
    push_ifid(b + 2,  32'h0,  32'h8C01_0004, 6'b100011, 32'h4);
    push_ifid(b + 7,  32'h4,  32'h0000_0820, 6'b000000, 32'h8);
    push_ifid(b + 9,  32'h8,  32'hC000_0008, 6'b110000, 32'hC);
    push_ifid(b + 11, 32'hC,  32'hC000_000C, 6'b110000, 32'h10);
    push_ifid(b + 19, 32'h40, 32'hC000_0040, 6'b110000, 32'h44);
    push_ifid(b + 23, 32'h20, 32'hC000_0020, 6'b110000, 32'h24);
    push_ifid(b + 25, 32'h24, 32'hC000_0024, 6'b110000, 32'h28);

    for (int k = 0; k <= 36; k++) begin
      if (k != 0) tick();
      reset       = (k == 26) ? 1'b0 : 1'b1;
      stall       = ((k >= 4) && (k <= 6)) || (k >= 33);
      redirect    = (k == 12) || (k == 20);
      redirect_pc = (k == 12) ? 32'h40 : ((k == 20) ? 32'h23 : 32'h0);
      inj         = (k == 27);
      if (k == 11 || k == 25) mem_lat = 3;
      if (k == 19 || k == 26) mem_lat = 1;
      if (k == 27) begin
        // Second run after the mid-request reset; the late word must never surface.
        push_req(b + 27, 32'h0); push_req(b + 29, 32'h4); push_req(b + 31, 32'h8);
        push_ifid(b + 29, 32'h0, 32'h8C01_0004, 6'b100011, 32'h4);
        push_ifid(b + 31, 32'h4, 32'h0000_0820, 6'b000000, 32'h8);
      end
      #3;
      case (k)
        0: begin
          chk("wrap_req0", {31'd0, req2}, 32'd1);
          chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
        end
        2: begin
          chk("wrap_if_valid", {31'd0, if_valid2}, 32'd1);
          chk("wrap_if_pc", if_pc2, 32'hFFFF_FFFC);
          chk("wrap_if_pcplus4", if_pcplus4_2, 32'h0);
          chk("wrap_req1", {31'd0, req2}, 32'd1);
          chk("wrap_addr1", addr2, 32'h0);
        end
        5: begin
          chk("stall_hold_valid", {31'd0, if_valid}, 32'd1);
          chk("stall_hold_pc", if_pc, 32'h4);
        end
        16: chk("discard_if_valid", {31'd0, if_valid}, 32'd0);
        26: check_reset_outputs("midreset");
        34: chk("final_hold_pc", if_pc, 32'h8);
        default: ;
      endcase
    end

    chk("left_req", exp_req.size(), 32'd0);
    chk("left_ifid", exp_ifid.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
